// File: rtl/fp16_pkg.sv
// FP16 field layout, constants and a leading-zero helper shared by the vector multiplier.
package fp16_pkg;
    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int BIAS   = 15;

    localparam logic [EXP_W-1:0] EXP_MAX   = 5'h1F;
    localparam logic [15:0]      FP16_INF  = 16'h7C00;
    localparam logic [15:0]      FP16_ZERO = 16'h0000;

    // Stage-0 state of one lane: everything needed to normalise the product later.
    typedef struct packed {
        logic              sign;
        logic              inf;
        logic [PROD_W-1:0] prod;
        logic [5:0]        esum;
    } raw_prod_t;

    function automatic logic [4:0] lzc22(input logic [PROD_W-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'(PROD_W);
        found = 1'b0;
        for (int i = PROD_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(PROD_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction
endpackage

// File: rtl/fp16_mul_lane.sv
// One FP16 multiplier lane: significand product into stage 0, normalise/truncate into
// stage 1, then plain delay registers so the result appears STAGES enables later.
module fp16_mul_lane
    import fp16_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        i_en,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_prod,
    output logic        o_ovf
);
    // Biased result exponent = esum + msb_index - NORM_OFS; subnormal units shift = esum - SUB_OFS.
    localparam int NORM_OFS = BIAS + 2 * MAN_W;
    localparam int SUB_OFS  = BIAS + MAN_W + 1;

    logic [EXP_W-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff;
    logic [SIG_W-1:0] w_sig_a, w_sig_b;
    raw_prod_t        w_raw, r_raw;

    always_comb begin
        w_ea       = i_a[14:10];
        w_eb       = i_b[14:10];
        w_ea_eff   = (w_ea == '0) ? 5'd1 : w_ea;
        w_eb_eff   = (w_eb == '0) ? 5'd1 : w_eb;
        w_sig_a    = {w_ea != '0, i_a[9:0]};
        w_sig_b    = {w_eb != '0, i_b[9:0]};
        w_raw.sign = i_a[15] ^ i_b[15];
        w_raw.inf  = (w_ea == EXP_MAX) || (w_eb == EXP_MAX);
        w_raw.prod = {11'b0, w_sig_a} * {11'b0, w_sig_b};
        w_raw.esum = 6'(w_ea_eff) + 6'(w_eb_eff);
    end

    logic [4:0]        w_lz;
    logic signed [7:0] w_exp, w_sh;
    logic [MAN_W-1:0]  w_man, w_frac;
    logic [15:0]       w_res;
    logic              w_ovf;

    always_comb begin
        w_lz  = lzc22(r_raw.prod);
        w_exp = 8'(int'(r_raw.esum) + (PROD_W - 1) - int'(w_lz) - NORM_OFS);
        w_sh  = 8'(int'(r_raw.esum) - SUB_OFS);
        w_man = 10'((r_raw.prod << w_lz) >> (MAN_W + 1));
        if (w_sh >= 0) begin
            w_frac = 10'(r_raw.prod << w_sh[5:0]);
        end else begin
            w_frac = 10'(r_raw.prod >> 6'(-w_sh));
        end

        w_res = FP16_ZERO;
        w_ovf = 1'b0;
        if (r_raw.inf || (r_raw.prod != '0 && w_exp >= 8'sd31)) begin
            w_res = FP16_INF;
            w_ovf = 1'b1;
        end else if (r_raw.prod == '0) begin
            w_res = FP16_ZERO;
        end else if (w_exp >= 8'sd1) begin
            w_res = {1'b0, w_exp[4:0], w_man};
        end else begin
            // Truncated subnormal; a zero fraction is the flush-to-zero case.
            w_res = {6'b0, w_frac};
        end
        w_res[15] = r_raw.sign;
    end

    logic [15:0] r_res [1:STAGES-1];
    logic        r_ovf [1:STAGES-1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_raw <= '0;
            for (int k = 1; k < STAGES; k++) begin
                r_res[k] <= '0;
                r_ovf[k] <= 1'b0;
            end
        end else if (i_en) begin
            r_raw    <= w_raw;
            r_res[1] <= w_res;
            r_ovf[1] <= w_ovf;
            for (int k = 2; k < STAGES; k++) begin
                r_res[k] <= r_res[k-1];
                r_ovf[k] <= r_ovf[k-1];
            end
        end
    end

    assign o_prod = r_res[STAGES-1];
    assign o_ovf  = r_ovf[STAGES-1];
endmodule

// File: rtl/smult_vec_pipe.sv
// Pipelined FP16 vector multiplier (scalar broadcast or elementwise) with a single
// valid/ready stall domain shared by all lanes.
module smult_vec_pipe
    import fp16_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int STAGES = 3
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [15:0]         scalar,
    input  logic [16*LANES-1:0] vec_a,
    input  logic [16*LANES-1:0] vec_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*LANES-1:0] product,
    output logic [LANES-1:0]    ovf,
    output logic                V,
    output logic                sticky_V,
    input  logic                clr_sticky,
    output logic                busy
);
    logic              w_adv;
    logic [STAGES-1:0] r_vld;
    logic              r_sticky;

    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES-1];
    assign busy      = |r_vld;
    assign V         = |ovf;
    assign sticky_V  = r_sticky;

    // Bubbles shift along with data so every stage moves in lock-step.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= {r_vld[STAGES-2:0], in_valid};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sticky <= 1'b0;
        end else if (out_valid && out_ready && V) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [15:0] w_a, w_b;

        // Mode is applied before stage 0, so it is captured with the operands.
        assign w_a = mode ? vec_a[16*i +: 16] : scalar;
        assign w_b = mode ? vec_b[16*i +: 16] : vec_a[16*i +: 16];

        fp16_mul_lane #(
            .STAGES(STAGES)
        ) u_lane (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .i_en  (w_adv),
            .i_a   (w_a),
            .i_b   (w_b),
            .o_prod(product[16*i +: 16]),
            .o_ovf (ovf[i])
        );
    end
endmodule

// File: doc/smult_vec_pipe.md
SMULT_VEC_PIPE -- requirements
Module: smult_vec_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning the number of FP16 lanes (legal range 1..32).
REQ-002 SHALL have parameter STAGES, default 3, meaning the pipeline latency in cycles (legal range 2..4).
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an operand set is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operand set this cycle.
REQ-007 SHALL have port mode, input, 1: 0 = scalar × vec_a broadcast; 1 = vec_a × vec_b elementwise.
REQ-008 SHALL have port scalar, input, 16, the FP16 broadcast operand (used when mode=0).
REQ-009 SHALL have port vec_a, input, 16*LANES, FP16 lanes; lane i occupies bits [16i+15:16i].
REQ-010 SHALL have port vec_b, input, 16*LANES, FP16 lanes (used when mode=1).
REQ-011 SHALL have port out_valid, output, 1, meaning product, ovf and V hold a result.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-013 SHALL have port product, output, 16*LANES, FP16 results in the same lane layout.
REQ-014 SHALL have port ovf, output, LANES, per-lane overflow flags of the presented result.
REQ-015 SHALL have port V, output, 1, the OR of ovf.
REQ-016 SHALL have port sticky_V, output, 1, set by any delivered result with V=1.
REQ-017 SHALL have port clr_sticky, input, 1, synchronous clear of sticky_V.
REQ-018 SHALL have port busy, output, 1, meaning any pipeline stage holds valid data.

Function
REQ-019 SHALL define advance = !out_valid | out_ready, drive in_ready = advance, and accept a transfer when in_valid & in_ready.
REQ-020 SHALL move all stages forward together on advance and freeze every stage, including outputs, when !advance.
REQ-021 SHALL present a result exactly STAGES cycles after acceptance when out_ready is held at 1; throughput is 1 operand set per cycle.
REQ-022 SHALL deliver results in acceptance order, with no drops or duplicates under arbitrary out_ready patterns.
REQ-023 SHALL capture mode per operand set at acceptance; mode changes do not affect in-flight data.
REQ-024 SHALL compute sign as the XOR of the operand signs and the magnitude as the 11x11 significand product with biased-exponent sum, handling subnormal inputs and outputs.
REQ-025 SHALL round toward zero (truncate) on all results.
REQ-026 SHALL flush results below the minimum subnormal to signed zero, without setting ovf.
REQ-027 SHALL saturate results above max finite to signed infinity (0x7C00/0xFC00) and set that lane's ovf.
REQ-028 SHALL treat any operand with exponent field 11111 as infinity, giving a signed-infinity result with ovf set, including inf×0.
REQ-029 SHALL give a signed-zero result with ovf=0 when either operand is zero and neither is exponent 11111.
REQ-030 SHALL set sticky_V on the cycle a result with V=1 transfers; when clr_sticky coincides with such a transfer, set wins.

Reset
REQ-031 SHALL on Rst_n low immediately clear all stage valids, out_valid, product, ovf, V, sticky_V and busy to 0; in_ready then equals 1.
REQ-032 SHALL discard in-flight data on reset mid-operation, producing no spurious out_valid after release.

Structure
REQ-033 SHALL place the FP16 field widths, bias (15), and the 0x7C00 infinity and 0x0000 zero constants in a shared package fp16_pkg.
REQ-034 SHALL instantiate LANES copies of sub-module fp16_mul_lane, with STAGES-deep registers and a shared stall enable; control lives in the top level only.

Verification
REQ-035 SHALL test mode=0, scalar=3C00, vec_a=all 3C00, out_ready=1 -> product all 3C00, V=0, out_valid 3 cycles after acceptance.
REQ-036 SHALL test mode=0, scalar=BC00, vec_a=all 3C00 -> product all BC00, V=0.
REQ-037 SHALL test mode=1, vec_a=all 7CCC, vec_b=all 7CDE -> product all 7C00, ovf all 1, V=1, sticky_V=1 until clr_sticky.
REQ-038 SHALL test mode=0, scalar=3C80, vec_a=all 0201 -> product all 0241 (subnormal truncation), V=0.
REQ-039 SHALL test 8 back-to-back transfers with out_ready toggling 1,0,0,1 -> in-order results, in_ready low exactly while stalled, none lost.
REQ-040 SHALL test Rst_n low with 3 transfers in flight -> all outputs 0 immediately and no out_valid for STAGES cycles after release.
